// File: rtl/if_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package if_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned HW_CNT_W  = 8;

    typedef logic [15:0]          halfword_t;
    typedef logic [HW_CNT_W-1:0]  hw_cnt_t;

    function automatic logic is_rvc(input halfword_t hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/if_fetch_buffer_if.sv
// Instruction-memory request/response bus between the fetch buffer and imem.
interface if_fetch_buffer_if;

    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_rvalid_i,
        output imem_rdata_i
    );

endinterface

// File: rtl/if_hw_fifo.sv
// Halfword circular FIFO: push 1 or 2, pop 1 or 2, synchronous flush,
// exposes the head and head+1 entries.
module if_hw_fifo
    import if_pkg::*;
#(
    parameter int unsigned DEPTH_HW = 8
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      flush,
    input  logic      push_en,
    input  logic      push_two,
    input  halfword_t push_lo,
    input  halfword_t push_hi,
    input  logic      pop_en,
    input  logic      pop_two,
    output hw_cnt_t   count,
    output halfword_t head0,
    output halfword_t head1
);

    localparam int unsigned PTR_W = $clog2(DEPTH_HW);
    typedef logic [PTR_W-1:0] ptr_t;

    halfword_t mem [DEPTH_HW];
    ptr_t      rd_ptr;
    ptr_t      wr_ptr;
    hw_cnt_t   push_n;
    hw_cnt_t   pop_n;
    logic      do_push;

    always_comb begin
        push_n = '0;
        pop_n  = '0;
        if (push_en) push_n = push_two ? hw_cnt_t'(2) : hw_cnt_t'(1);
        if (pop_en)  pop_n  = pop_two  ? hw_cnt_t'(2) : hw_cnt_t'(1);
    end

    assign do_push = resetn && !flush && push_en;

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + ptr_t'(push_n);
            rd_ptr <= rd_ptr + ptr_t'(pop_n);
            count  <= count + push_n - pop_n;
        end
    end

    // Storage carries no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_lo;
            if (push_two) mem[wr_ptr + ptr_t'(1)] <= push_hi;
        end
    end

    assign head0 = mem[rd_ptr];
    assign head1 = mem[rd_ptr + ptr_t'(1)];

endmodule

// File: rtl/if_fetch_buffer.sv
// Instruction-fetch front end: word fetches into a halfword FIFO, 32-bit window to ID.
// Optional macro IF_STALL_CNT_EN adds stall_cnt_o (ID-waiting-on-fetch cycle counter).
module if_fetch_buffer
    import if_pkg::*;
#(
    parameter int unsigned DEPTH_HW = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     enable,
    input  logic                     taken_i,
    input  logic [31:0]              redirection_pc_i,
    input  logic                     is_compressed_i,
    if_fetch_buffer_if.master        imem,
    output logic [31:0]              instruction_o,
    output logic                     instr_valid_o,
    output logic [31:0]              pc_o
`ifdef IF_STALL_CNT_EN
    ,
    output logic [31:0]              stall_cnt_o
`endif
);

    logic [31:0] fetch_pc;
    logic        skip_hw;
    logic        inflight;

    hw_cnt_t     count;
    halfword_t   head0;
    halfword_t   head1;

    logic        credit_ok;
    logic        head_valid;
    logic        push_en;
    logic        push_two;
    halfword_t   push_lo;
    logic        pop_en;
    logic        pop_two;

    // A request is issued only if its response plus any in-flight one still fits.
    always_comb begin
        credit_ok = (count + hw_cnt_t'({inflight, 1'b0}) + hw_cnt_t'(2)) <= hw_cnt_t'(DEPTH_HW);
        imem.imem_req_o  = resetn && !taken_i && credit_ok;
        imem.imem_addr_o = fetch_pc;
    end

    always_comb begin
        head_valid    = ((count >= hw_cnt_t'(1)) && is_rvc(head0)) || (count >= hw_cnt_t'(2));
        instr_valid_o = resetn && head_valid;
        instruction_o = NOP_INSTR;
        if (instr_valid_o) begin
            instruction_o = {(count >= hw_cnt_t'(2)) ? head1 : 16'h0000, head0};
        end
    end

    // Responses to requests issued before a redirect land in the redirect cycle
    // itself and are discarded there, so no separate drop flag is needed.
    always_comb begin
        pop_en   = enable && instr_valid_o && !taken_i;
        pop_two  = !is_compressed_i;
        push_en  = imem.imem_rvalid_i && !taken_i;
        push_two = !skip_hw;
        push_lo  = skip_hw ? imem.imem_rdata_i[31:16] : imem.imem_rdata_i[15:0];
    end

    if_hw_fifo #(
        .DEPTH_HW (DEPTH_HW)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .flush    (taken_i),
        .push_en  (push_en),
        .push_two (push_two),
        .push_lo  (push_lo),
        .push_hi  (imem.imem_rdata_i[31:16]),
        .pop_en   (pop_en),
        .pop_two  (pop_two),
        .count    (count),
        .head0    (head0),
        .head1    (head1)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_pc <= RESET_PC;
            pc_o     <= RESET_PC;
            skip_hw  <= 1'b0;
            inflight <= 1'b0;
        end else if (taken_i) begin
            fetch_pc <= {redirection_pc_i[31:2], 2'b00};
            pc_o     <= redirection_pc_i;
            skip_hw  <= redirection_pc_i[1];
            inflight <= 1'b0;
        end else begin
            inflight <= imem.imem_req_o;
            if (imem.imem_req_o) fetch_pc <= fetch_pc + 32'd4;
            if (pop_en)          pc_o     <= pc_o + (pop_two ? 32'd4 : 32'd2);
            if (push_en)         skip_hw  <= 1'b0;
        end
    end

`ifdef IF_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_cnt_o <= '0;
        end else if (enable && !instr_valid_o && !taken_i) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule
